// File: rtl/adder_uart_sequencer.sv
// Sequencer for a 64-bit adder behind a UART link: gathers A/B bytes, waits a settle
// window, then streams {cout, sum} back. Optional receive timeout: define RX_TIMEOUT_EN.
module adder_uart_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [63:0] op_a,
  output logic [63:0] op_b,
  input  logic [63:0] sum,
  input  logic        cout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Handshake: a result byte transfers on every rising edge where tx_valid && tx_ready;
  // tx_valid/tx_data hold until then. rx_valid is a one-cycle strobe with no backpressure.
  typedef enum logic [1:0] {RX_A, RX_B, SETTLE, TX} state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   settle_q, settle_d;
  logic [63:0]  op_a_q, op_a_d;
  logic [63:0]  op_b_q, op_b_d;
  logic [71:0]  res_q, res_d;
  logic         tx_valid_q, tx_valid_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         timeout;
  logic         tx_fire;
  logic         settle_end;
  logic [7:0]   tx_byte;

  assign tx_fire    = tx_valid_q && tx_ready;
  assign settle_end = (settle_q == SETTLE_LAST);

`ifdef RX_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              idle_active;

  // Idle time only counts once an operation has started and is still receiving.
  assign idle_active = ((state_q == RX_A) && (cnt_q != 3'd0)) || (state_q == RX_B);
  assign timeout     = idle_active && !rx_valid && (idle_q == IDLE_LAST);
  assign idle_d      = (idle_active && !rx_valid && !timeout) ? idle_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  // TIMEOUT_CYCLES is at least 2 in any legal build, so this folds to 0.
  assign timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RX_A;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_A:    if (rx_valid && cnt_q == 3'd7) state_d = RX_B;
      RX_B:    if (rx_valid && cnt_q == 3'd7) state_d = SETTLE;
               else if (timeout)              state_d = RX_A;
      SETTLE:  if (settle_end)                state_d = TX;
      TX:      if (tx_fire && idx_q == 4'd8)  state_d = RX_A;
      default: state_d = RX_A;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_d      = res_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      RX_A: begin
        if (rx_valid) begin
          op_a_d[{cnt_q, 3'b000} +: 8] = rx_data;
          cnt_d = cnt_q + 3'd1;
        end else if (timeout) begin
          cnt_d = 3'd0;
          err_d = 1'b1;
        end
      end
      RX_B: begin
        if (rx_valid) begin
          op_b_d[{cnt_q, 3'b000} +: 8] = rx_data;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) settle_d = 8'd0;
        end else if (timeout) begin
          cnt_d = 3'd0;
          err_d = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_end) begin
          res_d      = {7'b0, cout, sum};
          idx_d      = 4'd0;
          tx_valid_d = 1'b1;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      TX: begin
        if (tx_fire) begin
          if (idx_q == 4'd8) begin
            idx_d      = 4'd0;
            cnt_d      = 3'd0;
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 3'd0;
      idx_q      <= 4'd0;
      settle_q   <= 8'd0;
      op_a_q     <= 64'd0;
      op_b_q     <= 64'd0;
      res_q      <= 72'd0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_q      <= res_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    tx_byte = 8'd0;
    for (int i = 0; i < 9; i++) begin
      if (idx_q == 4'(i)) tx_byte = res_q[i*8 +: 8];
    end
  end

  always_comb begin
    tx_data  = tx_valid_q ? tx_byte : 8'd0;
    tx_valid = tx_valid_q;
    op_a     = op_a_q;
    op_b     = op_b_q;
    busy     = !((state_q == RX_A) && (cnt_q == 3'd0));
    done     = done_q;
    err      = err_q;
  end

endmodule
